// File: rtl/clock_set_ctrl.sv
// RUN/SET front end for the sec/min/hour clock chain: input synchronisers, mode FSM,
// 1 Hz prescaler, hold-to-repeat increment pulses and the edit-field blink mask.
module clock_set_ctrl #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000,
  parameter int BLINK_HALF   = 12_500_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_mode_n,
  input  logic       key_up_n,
  input  logic       sw_set,
  output logic       tick_1hz,
  output logic [2:0] up,
  output logic       set,
  output logic [1:0] field,
  output logic [2:0] blank
);

  localparam int CW   = $clog2(CLK_HZ);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX);
  localparam int BW   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [CW-1:0] PRE_LAST  = CW'(CLK_HZ - 1);
  localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);
  localparam logic [BW-1:0] BLK_LAST  = BW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_SEC  = 2'd1,
    SET_MIN  = 2'd2,
    SET_HOUR = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          modeMeta_q, modeSync_q, modePrev_q;
  logic          upMeta_q, upSync_q, upPrev_q;
  logic          swMeta_q, swSync_q;
  logic [CW-1:0] preCnt_q, preCnt_d;
  logic [RW-1:0] repCnt_q, repCnt_d;
  logic          repActive_q, repActive_d;
  logic          repFirst_q, repFirst_d;
  logic [BW-1:0] blkCnt_q, blkCnt_d;
  logic          phase_q, phase_d;
  logic          tick_q, tick_d;
  logic [2:0]    up_q, up_d;
  logic          set_q, set_d;
  logic [2:0]    blank_q, blank_d;

  logic       modePress, upPress, upHeld, fieldChange, editing;
  logic [2:0] sel;

  function automatic logic [2:0] selOneHot(input state_t s);
    case (s)
      SET_SEC:  selOneHot = 3'b001;
      SET_MIN:  selOneHot = 3'b010;
      SET_HOUR: selOneHot = 3'b100;
      default:  selOneHot = 3'b000;
    endcase
  endfunction

  // Key synchronisers reset to the released level so reset never looks like a press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      modeMeta_q <= 1'b1;
      modeSync_q <= 1'b1;
      modePrev_q <= 1'b1;
      upMeta_q   <= 1'b1;
      upSync_q   <= 1'b1;
      upPrev_q   <= 1'b1;
      swMeta_q   <= 1'b0;
      swSync_q   <= 1'b0;
    end else begin
      modeMeta_q <= key_mode_n;
      modeSync_q <= modeMeta_q;
      modePrev_q <= modeSync_q;
      upMeta_q   <= key_up_n;
      upSync_q   <= upMeta_q;
      upPrev_q   <= upSync_q;
      swMeta_q   <= sw_set;
      swSync_q   <= swMeta_q;
    end
  end

  assign modePress = modePrev_q & ~modeSync_q;
  assign upPress   = upPrev_q & ~upSync_q;
  assign upHeld    = ~upSync_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: if (swSync_q) state_d = SET_SEC;
      default: begin
        if (!swSync_q) begin
          state_d = RUN;
        end else if (modePress) begin
          case (state_q)
            SET_SEC: state_d = SET_MIN;
            SET_MIN: state_d = SET_HOUR;
            default: state_d = SET_SEC;
          endcase
        end
      end
    endcase
  end

  // A field change (including SET entry/exit) cancels any press or repeat on that cycle.
  assign fieldChange = (state_d != state_q);
  assign editing     = (state_q != RUN) && !fieldChange;
  assign sel         = selOneHot(state_q);

  always_comb begin
    preCnt_d    = '0;
    tick_d      = 1'b0;
    up_d        = 3'b000;
    repCnt_d    = '0;
    repActive_d = 1'b0;
    repFirst_d  = 1'b0;
    blkCnt_d    = '0;
    phase_d     = 1'b0;
    blank_d     = 3'b000;
    set_d       = (state_d != RUN);

    if (state_q == RUN && state_d == RUN) begin
      if (preCnt_q == PRE_LAST) begin
        tick_d = 1'b1;
      end else begin
        preCnt_d = preCnt_q + 1'b1;
      end
    end

    if (editing && upPress) begin
      up_d        = sel;
      repActive_d = 1'b1;
      repFirst_d  = 1'b1;
    end else if (editing && repActive_q && upHeld) begin
      repActive_d = 1'b1;
      repFirst_d  = repFirst_q;
      if (repCnt_q == (repFirst_q ? DLY_LAST : RATE_LAST)) begin
        up_d       = sel;
        repFirst_d = 1'b0;
      end else begin
        repCnt_d = repCnt_q + 1'b1;
      end
    end

    if (state_d != RUN && !fieldChange) begin
      if (blkCnt_q == BLK_LAST) begin
        phase_d = ~phase_q;
      end else begin
        phase_d  = phase_q;
        blkCnt_d = blkCnt_q + 1'b1;
      end
    end

    if (state_d != RUN && !upHeld && phase_d) begin
      blank_d = selOneHot(state_d);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      preCnt_q    <= '0;
      repCnt_q    <= '0;
      repActive_q <= 1'b0;
      repFirst_q  <= 1'b0;
      blkCnt_q    <= '0;
      phase_q     <= 1'b0;
      tick_q      <= 1'b0;
      up_q        <= 3'b000;
      set_q       <= 1'b0;
      blank_q     <= 3'b000;
    end else begin
      state_q     <= state_d;
      preCnt_q    <= preCnt_d;
      repCnt_q    <= repCnt_d;
      repActive_q <= repActive_d;
      repFirst_q  <= repFirst_d;
      blkCnt_q    <= blkCnt_d;
      phase_q     <= phase_d;
      tick_q      <= tick_d;
      up_q        <= up_d;
      set_q       <= set_d;
      blank_q     <= blank_d;
    end
  end

  assign tick_1hz = tick_q;
  assign up       = up_q;
  assign set      = set_q;
  assign field    = state_q;
  assign blank    = blank_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: expected tick/up pulses are queued with their cycle number
// when stimulus is driven and matched by a negedge monitor as the DUT emits them.
module tb_clock_set_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       key_mode_n;
  logic       key_up_n;
  logic       sw_set;
  logic       tick_1hz;
  logic [2:0] up;
  logic       set;
  logic [1:0] field;
  logic [2:0] blank;

  int cyc = 0;
  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    int         c;
    logic [2:0] v;
  } upExp_t;

  upExp_t expUp[$];
  int     expTick[$];
  upExp_t monUp;
  int     monTick;

  clock_set_ctrl #(
    .CLK_HZ(10),
    .REPEAT_DELAY(8),
    .REPEAT_RATE(3),
    .BLINK_HALF(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .key_mode_n(key_mode_n),
    .key_up_n(key_up_n),
    .sw_set(sw_set),
    .tick_1hz(tick_1hz),
    .up(up),
    .set(set),
    .field(field),
    .blank(blank)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Every emitted pulse must match the oldest queued expectation, cycle and value.
  always @(negedge clock) begin
    if (tick_1hz !== 1'b0) begin
      testsRun++;
      if (expTick.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL tick_unexpected: tick_1hz=%b at cycle %0d, expected no pulse", tick_1hz, cyc);
      end else begin
        monTick = expTick.pop_front();
        if (monTick != cyc) begin
          testsFailed++;
          $display("[TB] FAIL tick_cycle: pulse at cycle %0d, expected at cycle %0d", cyc, monTick);
        end
      end
    end
    if (up !== 3'b000) begin
      testsRun++;
      if (expUp.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL up_unexpected: up=%b at cycle %0d, expected no pulse", up, cyc);
      end else begin
        monUp = expUp.pop_front();
        if (monUp.c != cyc || monUp.v !== up) begin
          testsFailed++;
          $display("[TB] FAIL up_pulse: up=%b at cycle %0d, expected up=%b at cycle %0d", up, cyc, monUp.v, monUp.c);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic pushUp(input int c, input logic [2:0] v);
    upExp_t e;
    e.c = c;
    e.v = v;
    expUp.push_back(e);
  endtask

  task automatic tapMode();
    key_mode_n = 1'b0;
    repeat (3) @(negedge clock);
    key_mode_n = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic tapUp();
    key_up_n = 1'b0;
    repeat (3) @(negedge clock);
    key_up_n = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    key_mode_n = 1'b1;
    key_up_n   = 1'b1;
    sw_set     = 1'b0;
    repeat (3) @(negedge clock);
    testsRun++;
    if ({tick_1hz, up, set, field, blank} !== 10'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: tick=%b up=%b set=%b field=%0d blank=%b, expected all 0",
               tick_1hz, up, set, field, blank);
    end
    reset = 1'b0;
  endtask

  task automatic test_run_ticks();
    int base;
    base = cyc;
    expTick.push_back(base + 10);
    expTick.push_back(base + 20);
    expTick.push_back(base + 30);
    for (int i = 0; i < 35; i++) begin
      @(negedge clock);
      testsRun++;
      if (set !== 1'b0 || field !== 2'd0) begin
        testsFailed++;
        $display("[TB] FAIL run_state: set=%b field=%0d at cycle %0d, expected set=0 field=0", set, field, cyc);
      end
    end
    testsRun++;
    if (expTick.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL run_ticks_missing: %0d ticks outstanding, expected 0", expTick.size());
    end
  endtask

  task automatic test_set_entry();
    sw_set = 1'b1;
    repeat (2) @(negedge clock);
    testsRun++;
    if (set !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL set_early: set=%b two cycles after switch, expected 0", set);
    end
    @(negedge clock);
    testsRun++;
    if (set !== 1'b1 || field !== 2'd1) begin
      testsFailed++;
      $display("[TB] FAIL set_entry: set=%b field=%0d, expected set=1 field=1", set, field);
    end
    pushUp(cyc + 3, 3'b001);
    tapUp();
    repeat (2) @(negedge clock);
    testsRun++;
    if (expUp.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL set_up_missing: %0d up pulses outstanding, expected 0", expUp.size());
    end
  endtask

  task automatic test_mode_cycle();
    tapMode();
    testsRun++;
    if (field !== 2'd2) begin
      testsFailed++;
      $display("[TB] FAIL mode_to_min: field=%0d, expected 2", field);
    end
    tapMode();
    testsRun++;
    if (field !== 2'd3) begin
      testsFailed++;
      $display("[TB] FAIL mode_to_hour: field=%0d, expected 3", field);
    end
    pushUp(cyc + 3, 3'b100);
    tapUp();
    testsRun++;
    if (expUp.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL hour_up_missing: %0d up pulses outstanding, expected 0", expUp.size());
    end
    tapMode();
    testsRun++;
    if (field !== 2'd1) begin
      testsFailed++;
      $display("[TB] FAIL mode_wrap: field=%0d, expected 1", field);
    end
  endtask

  task automatic test_repeat();
    int base;
    tapMode();
    testsRun++;
    if (field !== 2'd2) begin
      testsFailed++;
      $display("[TB] FAIL repeat_field: field=%0d, expected 2", field);
    end
    base = cyc;
    pushUp(base + 3, 3'b010);
    pushUp(base + 11, 3'b010);
    pushUp(base + 14, 3'b010);
    pushUp(base + 17, 3'b010);
    pushUp(base + 20, 3'b010);
    key_up_n = 1'b0;
    repeat (20) @(negedge clock);
    key_up_n = 1'b1;
    repeat (8) @(negedge clock);
    testsRun++;
    if (expUp.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL repeat_missing: %0d up pulses outstanding, expected 0", expUp.size());
    end
  endtask

  task automatic test_blink();
    logic [2:0] expB;
    int         base;
    tapMode();
    key_mode_n = 1'b0;
    repeat (3) @(negedge clock);
    key_mode_n = 1'b1;
    testsRun++;
    if (field !== 2'd1) begin
      testsFailed++;
      $display("[TB] FAIL blink_field: field=%0d, expected 1", field);
    end
    for (int k = 0; k < 16; k++) begin
      expB = (((k / 4) % 2) == 1) ? 3'b001 : 3'b000;
      testsRun++;
      if (blank !== expB) begin
        testsFailed++;
        $display("[TB] FAIL blink_phase: blank=%b at step %0d, expected %b", blank, k, expB);
      end
      @(negedge clock);
    end
    base = cyc;
    pushUp(base + 3, 3'b001);
    key_up_n = 1'b0;
    repeat (3) @(negedge clock);
    for (int k = 0; k < 6; k++) begin
      if (k == 3) key_up_n = 1'b1;
      testsRun++;
      if (blank !== 3'b000) begin
        testsFailed++;
        $display("[TB] FAIL blink_held: blank=%b at step %0d while key held, expected 000", blank, k);
      end
      @(negedge clock);
    end
    repeat (4) @(negedge clock);
    testsRun++;
    if (expUp.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL blink_up_missing: %0d up pulses outstanding, expected 0", expUp.size());
    end
  endtask

  task automatic test_simultaneous();
    key_mode_n = 1'b0;
    key_up_n   = 1'b0;
    repeat (12) @(negedge clock);
    key_mode_n = 1'b1;
    key_up_n   = 1'b1;
    repeat (5) @(negedge clock);
    testsRun++;
    if (field !== 2'd2) begin
      testsFailed++;
      $display("[TB] FAIL simultaneous_field: field=%0d, expected 2", field);
    end
  endtask

  task automatic test_reset_midhold();
    tapMode();
    testsRun++;
    if (field !== 2'd3) begin
      testsFailed++;
      $display("[TB] FAIL midhold_field: field=%0d, expected 3", field);
    end
    pushUp(cyc + 3, 3'b100);
    key_up_n = 1'b0;
    repeat (5) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    testsRun++;
    if ({tick_1hz, up, set, field, blank} !== 10'd0) begin
      testsFailed++;
      $display("[TB] FAIL async_reset: tick=%b up=%b set=%b field=%0d blank=%b, expected all 0",
               tick_1hz, up, set, field, blank);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    testsRun++;
    if (set !== 1'b1 || field !== 2'd1) begin
      testsFailed++;
      $display("[TB] FAIL reset_reentry: set=%b field=%0d, expected set=1 field=1", set, field);
    end
    repeat (2) @(negedge clock);
    key_up_n = 1'b1;
    repeat (6) @(negedge clock);
    testsRun++;
    if (expUp.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL midhold_up_missing: %0d up pulses outstanding, expected 0", expUp.size());
    end
  endtask

  task automatic test_exit_run();
    int base;
    base = cyc;
    expTick.push_back(base + 13);
    sw_set = 1'b0;
    repeat (3) @(negedge clock);
    testsRun++;
    if (set !== 1'b0 || field !== 2'd0) begin
      testsFailed++;
      $display("[TB] FAIL exit_state: set=%b field=%0d, expected set=0 field=0", set, field);
    end
    repeat (13) @(negedge clock);
    testsRun++;
    if (expTick.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL exit_tick_missing: %0d ticks outstanding, expected 0", expTick.size());
    end
  endtask

  initial begin
    test_reset();
    test_run_ticks();
    test_set_entry();
    test_mode_cycle();
    test_repeat();
    test_blink();
    test_simultaneous();
    test_reset_midhold();
    test_exit_run();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
